// File: rtl/uart_bus_bridge_pkg.sv
// Shared definitions for the UART-to-bus debug bridge.
// Holds the bus geometry, the command and reply byte codes, and the parser state encoding.
package uart_bus_bridge_pkg;

  localparam int unsigned BusWidth    = 32;
  localparam int unsigned BusAccWidth = 2;
  localparam logic [BusAccWidth-1:0] BusAcc4B = 2'b10;

  localparam logic [7:0] CmdW    = 8'h57;
  localparam logic [7:0] CmdR    = 8'h52;
  localparam logic [7:0] CmdP    = 8'h50;
  localparam logic [7:0] RespAck = 8'h06;
  localparam logic [7:0] RespNak = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBusReq,
    StBusWait,
    StTxData,
    StTxStat
  } state_e;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Femto system bus, debug-master view.
// master: drives addr/w_rb/acc/wdata/req, receives rdata/resp/fault.
// slave:  the mirror image, used by the arbiter port (or a bench model).
interface uart_bus_bridge_if;
  import uart_bus_bridge_pkg::*;

  logic [BusWidth-1:0]    addr;
  logic                   w_rb;
  logic [BusAccWidth-1:0] acc;
  logic [BusWidth-1:0]    wdata;
  logic [BusWidth-1:0]    rdata;
  logic                   req;
  logic                   resp;
  logic                   fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );
endinterface

// File: rtl/uart_bus_bridge_txsel.sv
// Tx queue push pacing and reply byte multiplexer.
// Ports: clk/rstn; txq_full from the UART tx queue; send_data/send_stat say which kind of byte
// the parser wants to emit; byte_sel picks the rdata byte (LSB first); tx_push/tx_data go to
// the tx queue.
module uart_bus_bridge_txsel (
  input  logic        clk,
  input  logic        rstn,
  input  logic        txq_full,
  input  logic        send_data,
  input  logic        send_stat,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] rdata,
  input  logic [7:0]  status,
  output logic        tx_push,
  output logic [7:0]  tx_data
);

  logic push_q;

  // Skipping the cycle after a push gives the queue's full flag time to catch up.
  assign tx_push = (send_data | send_stat) & ~txq_full & ~push_q;

  always_comb begin
    tx_data = 8'h00;
    if (send_stat) begin
      tx_data = status;
    end else if (send_data) begin
      tx_data = rdata[{byte_sel, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_q <= 1'b0;
    end else begin
      push_q <= tx_push;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-to-bus debug bridge: parses W/R/P commands from the UART rx queue, runs one bus transfer
// as debug master and answers through the UART tx queue.
// Ports: clk, rstn (async, active-low); rxq_empty/rx_pop/rx_data (rx queue read side);
// txq_full/tx_push/tx_data (tx queue write side); bus (femto bus master); busy (not idle).
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter logic [15:0] ByteTimeout = 16'd50000,
  parameter logic [7:0]  BusTimeout  = 8'd255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rxq_empty,
  output logic                   rx_pop,
  input  logic [7:0]             rx_data,
  input  logic                   txq_full,
  output logic                   tx_push,
  output logic [7:0]             tx_data,
  uart_bus_bridge_if.master      bus,
  output logic                   busy
);

  localparam logic [15:0] BusLimit = {8'h00, BusTimeout} - 16'd1;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                cmd_w_q, cmd_w_d;
  logic [BusWidth-1:0] addr_q, addr_d;
  logic [BusWidth-1:0] wdata_q, wdata_d;
  logic [BusWidth-1:0] rdata_q, rdata_d;
  logic [7:0]          status_q, status_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                rx_pop_q, rx_pop_d;
  logic                rx_vld_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_w_d  = cmd_w_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      StIdle: begin
        tmo_d = 16'd0;
        if (rx_vld_q) begin
          cnt_d = 2'd0;
          unique case (rx_data)
            CmdW: begin
              cmd_w_d = 1'b1;
              state_d = StAddr;
            end
            CmdR: begin
              cmd_w_d = 1'b0;
              state_d = StAddr;
            end
            CmdP: begin
              status_d = RespAck;
              state_d  = StTxStat;
            end
            default: begin
              status_d = RespNak;
              state_d  = StTxStat;
            end
          endcase
        end
      end
      StAddr, StData: begin
        if (rx_vld_q) begin
          tmo_d = 16'd0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == StAddr) begin
            addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
          end else begin
            wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
          end
          if (cnt_q == 2'd3) begin
            state_d = (state_q == StAddr && cmd_w_q) ? StData : StBusReq;
          end
        end else if (tmo_q >= ByteTimeout) begin
          // Stalled host: drop the command without any reply or bus access.
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StBusReq: begin
        tmo_d = 16'd0;
        if (bus.fault) begin
          status_d = RespNak;
          state_d  = StTxStat;
        end else begin
          state_d = StBusWait;
        end
      end
      StBusWait: begin
        if (bus.resp) begin
          if (cmd_w_q) begin
            status_d = RespAck;
            state_d  = StTxStat;
          end else begin
            rdata_d = bus.rdata;
            cnt_d   = 2'd0;
            state_d = StTxData;
          end
        end else if (tmo_q >= BusLimit) begin
          status_d = RespNak;
          state_d  = StTxStat;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StTxData: begin
        if (tx_push) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            status_d = RespAck;
            state_d  = StTxStat;
          end
        end
      end
      StTxStat: begin
        if (tx_push) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pop decision looks at the next state so a byte is never pulled into a non-parsing state.
  assign rx_pop_d = (state_d == StIdle || state_d == StAddr || state_d == StData) &
                    ~rxq_empty & ~rx_pop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      cmd_w_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= 8'h00;
      tmo_q    <= 16'd0;
      rx_pop_q <= 1'b0;
      rx_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_w_q  <= cmd_w_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      rx_pop_q <= rx_pop_d;
      rx_vld_q <= rx_pop_q;
    end
  end

  uart_bus_bridge_txsel u_txsel (
    .clk       (clk),
    .rstn      (rstn),
    .txq_full  (txq_full),
    .send_data (state_q == StTxData),
    .send_stat (state_q == StTxStat),
    .byte_sel  (cnt_q),
    .rdata     (rdata_q),
    .status    (status_q),
    .tx_push   (tx_push),
    .tx_data   (tx_data)
  );

  assign rx_pop    = rx_pop_q;
  assign busy      = (state_q != StIdle);
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.w_rb  = cmd_w_q;
  assign bus.acc   = BusAcc4B;
  assign bus.req   = (state_q == StBusReq);

endmodule
